result_collector: RTL and testbench
===================================

// Module: result_collector
// PURPOSE
//  Drain end of the systolic-array datapath. After the dispatcher latches done_dispatch, it waits
//  for the M x K result matrix held in the PE accumulators. It packs results row-major, BW words
//  per beat, into the output FIFO. It then flags done_collect and pulses pe_clear so the array can
//  accept the next job.
// PARAMETERS
//  M   2  rows of the result matrix (rows of A); >=1
//  K   2  cols of the result matrix (cols of B); K % BW == 0 (checked by elaboration assertion)
//  BW  2  words (word_t) per output FIFO entry; >=1
// PORTS
//  clk            in   1                 clock
//  nrst           in   1                 reset, asynchronous, active-low
//  out_fifo_if    FIFO_if.master         output buffer: drives push, dat_in[0:BW-1]; samples is_full
//  done_dispatch  in   1                 dispatcher has shifted all operands into the array
//  restart        in   1                 synchronous soft restart: return to IDLE for next job
//  res_dat        in   word_t [M][K]     per-PE accumulated result
//  res_valid      in   1 [M][K]          per-PE result final (held until pe_clear)
//  done_collect   out  1                 all M*K results pushed; sticky
//  pe_clear       out  1                 one-cycle pulse: clear PE accumulators and res_valid
//  busy           out  1                 high in WAIT_RES or COLLECT
// BEHAVIOUR
//  Reset: state=IDLE, row_ctr=0, col_ctr=0, done_collect=0, pe_clear=0, busy=0, push=0, dat_in='0.
//  Counters: row_ctr width $clog2(M)+1; col_ctr width $clog2(K)+1. col_ctr steps by BW.
//  Group (r,c) = res[r][c .. c+BW-1].
//  grp_valid = AND of res_valid over the current group.
//  FSM:
//   IDLE     : done_dispatch=1 -> WAIT_RES (next cycle).
//   WAIT_RES : grp_valid -> COLLECT. Otherwise hold; there is no timeout.
//   COLLECT  : push = grp_valid & ~is_full (combinational from registered counters).
//              dat_in[i] = res_dat[row_ctr][col_ctr+i]; dat_in='0 when push=0.
//              On push: col_ctr += BW. If col_ctr == K-BW, col_ctr=0 and row_ctr++.
//              Push of the last group (row_ctr==M-1, col_ctr==K-BW) -> DONE.
//              Counters are reset to 0 on that push.
//              grp_valid=0 -> back to WAIT_RES. is_full & grp_valid -> stall: counters hold, no push.
//   DONE     : done_collect=1 (registered, asserted the cycle after the last push).
//              pe_clear=1 for exactly the first cycle in DONE.
//              Remain in DONE until restart or nrst.
//  restart (any state): next state IDLE; counters=0; done_collect=0; pe_clear=0. Has priority over
//   all other transitions. restart in the same cycle as a push: the push still completes this cycle,
//   but the counters are not advanced.
//  done_dispatch dropping after IDLE is ignored. The job proceeds to completion.
//  Latency: a group that is valid on entry to COLLECT with the FIFO not full pushes in its first
//   COLLECT cycle. Steady state is 1 group/cycle. Total >= M*K/BW cycles in COLLECT.
//  Each group pushes exactly once. No reordering. Order is row-major: (0,0),(0,BW),...,(M-1,K-BW).
//  Async reset mid-job: everything returns to reset values immediately. Results already in the
//   FIFO are not recalled.
//  Arithmetic: words are passed through unmodified. No saturation or truncation.
// TESTING (M=2,K=2,BW=2 unless noted)
//  1 res=[[1,2],[3,4]] all valid, done_dispatch pulse, FIFO empty -> pushes {1,2} then {3,4} on
//    consecutive cycles. done_collect rises the cycle after; pe_clear high exactly 1 cycle.
//  2 As 1 with is_full=1 for 3 cycles at the 2nd group -> {3,4} is pushed once, after is_full drops.
//    No duplicate push; dat_in='0 while stalled.
//  3 done_dispatch=1 with res_valid[1][1]=0 -> {1,2} pushed, then FSM sits in WAIT_RES.
//    Setting res_valid[1][1]=1 -> {3,4} pushed next COLLECT cycle.
//  4 nrst asserted after the first push -> outputs at reset values. Rerun of 1 -> exactly 2 pushes.
//  5 In DONE, pulse restart, then redo 1 with res=[[5,6],[7,8]] -> pushes {5,6},{7,8}.
//    done_collect low in between.
//  6 M=2,K=4,BW=2, res=[[1..4],[5..8]] -> 4 pushes: {1,2},{3,4},{5,6},{7,8}.
//    Counter wrap is correct.

Source files
------------

// File: rtl/result_collector.sv
// rtl/result_collector.sv - drains the PE result matrix into the output FIFO, row-major
//
// Purpose
//   Drain end of the systolic array. Once the dispatcher reports done_dispatch_i, the
//   collector walks the M x K result matrix in row-major order. It packs BW words per
//   FIFO beat. Each group is pushed as soon as all of its PEs flag a final result and
//   the FIFO has room. After the last group the collector raises a sticky
//   done_collect_o and gives a single-cycle pe_clear_o pulse, so the array can start
//   the next job.
//
// Ports
//   clk              clock
//   nrst             asynchronous active-low reset
//   done_dispatch_i  dispatcher has shifted all operands into the array (sampled in IDLE only)
//   restart_i        synchronous soft restart back to IDLE; wins over every other transition
//   res_dat_i        per-PE accumulated result, indexed [row][col]
//   res_valid_i      per-PE "result final" flag, indexed [row][col], held until pe_clear_o
//   fifo_full_i      output FIFO cannot accept a beat this cycle
//   fifo_push_o      push one beat into the output FIFO
//   fifo_dat_o       beat payload; lane i carries res[row][col+i] (lane 0 in the low word)
//   done_collect_o   all M*K results pushed; sticky until restart_i or nrst
//   pe_clear_o       one-cycle pulse on entry to DONE: clear PE accumulators and valids
//   busy_o           high while waiting for or collecting results

module result_collector #(
  parameter int M  = 2,   // rows of the result matrix
  parameter int K  = 2,   // columns of the result matrix, multiple of BW
  parameter int BW = 2,   // words per output beat
  parameter int W  = 16   // word width
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       done_dispatch_i,
  input  logic                       restart_i,
  input  logic [M-1:0][K-1:0][W-1:0] res_dat_i,
  input  logic [M-1:0][K-1:0]        res_valid_i,
  input  logic                       fifo_full_i,
  output logic                       fifo_push_o,
  output logic [BW-1:0][W-1:0]       fifo_dat_o,
  output logic                       done_collect_o,
  output logic                       pe_clear_o,
  output logic                       busy_o
);

  // Counter widths carry one spare bit beyond the index range.
  localparam int RW  = $clog2(M) + 1;
  localparam int CW  = $clog2(K) + 1;
  // Index widths used to address the packed result arrays.
  localparam int RIW = (M > 1) ? $clog2(M) : 1;
  localparam int CIW = (K > 1) ? $clog2(K) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(K - BW);
  localparam logic [CW-1:0] COL_STEP = CW'(BW);

  // Elaboration-time parameter checks.
  if (K % BW != 0) begin : g_bad_k
    $error("result_collector: K must be a multiple of BW");
  end
  if (M < 1 || BW < 1) begin : g_bad_dims
    $error("result_collector: M and BW must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RES = 2'd1,
    S_COLLECT  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t            state_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              done_collect_q;
  logic              pe_clear_q;
  logic              busy_q;

  logic              grp_valid;
  logic [BW-1:0][W-1:0] grp_dat;
  logic [CW-1:0]     col_idx;
  logic              push;
  logic              last_grp;
  logic              row_end;

  // Select the current group res[row_q][col_q .. col_q+BW-1] and AND its valid flags.
  always_comb begin
    grp_valid = 1'b1;
    grp_dat   = '0;
    col_idx   = '0;
    for (int i = 0; i < BW; i++) begin
      col_idx    = col_q + CW'(i);
      grp_valid  = grp_valid & res_valid_i[row_q[RIW-1:0]][col_idx[CIW-1:0]];
      grp_dat[i] = res_dat_i[row_q[RIW-1:0]][col_idx[CIW-1:0]];
    end
  end

  // Push is combinational from the registered counters, so a group that is already
  // valid when COLLECT is entered goes out in that first COLLECT cycle.
  assign push     = (state_q == S_COLLECT) && grp_valid && !fifo_full_i;
  assign row_end  = (col_q == COL_LAST);
  assign last_grp = row_end && (row_q == ROW_LAST);

  assign fifo_push_o    = push;
  assign fifo_dat_o     = push ? grp_dat : '0;
  assign done_collect_o = done_collect_q;
  assign pe_clear_o     = pe_clear_q;
  assign busy_o         = busy_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= S_IDLE;
      row_q          <= '0;
      col_q          <= '0;
      done_collect_q <= 1'b0;
      pe_clear_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else if (restart_i) begin
      // A push coinciding with restart still reaches the FIFO (push is combinational),
      // but the counters start over from the first group.
      state_q        <= S_IDLE;
      row_q          <= '0;
      col_q          <= '0;
      done_collect_q <= 1'b0;
      pe_clear_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pe_clear_q <= 1'b0;
          if (done_dispatch_i) begin
            state_q <= S_WAIT_RES;
            busy_q  <= 1'b1;
          end
        end

        S_WAIT_RES: begin
          // No timeout: the array is expected to finish eventually.
          if (grp_valid) begin
            state_q <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (push) begin
            if (last_grp) begin
              state_q        <= S_DONE;
              row_q          <= '0;
              col_q          <= '0;
              done_collect_q <= 1'b1;
              pe_clear_q     <= 1'b1;
              busy_q         <= 1'b0;
            end else if (row_end) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + COL_STEP;
            end
          end else if (!grp_valid) begin
            state_q <= S_WAIT_RES;
          end
          // grp_valid with a full FIFO: stall with counters held.
        end

        S_DONE: begin
          // pe_clear is only high for the first DONE cycle.
          pe_clear_q <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - directed self-checking bench for result_collector

module tb_result_collector;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // DUT A: M=2, K=2, BW=2
  logic                  a_dd, a_rs, a_full;
  logic [1:0][1:0][15:0] a_res;
  logic [1:0][1:0]       a_vld;
  logic                  a_push, a_done, a_pe, a_busy;
  logic [1:0][15:0]      a_out;

  // DUT B: M=2, K=4, BW=2
  logic                  b_dd, b_rs, b_full;
  logic [1:0][3:0][15:0] b_res;
  logic [1:0][3:0]       b_vld;
  logic                  b_push, b_done, b_pe, b_busy;
  logic [1:0][15:0]      b_out;

  result_collector #(.M(2), .K(2), .BW(2), .W(16)) u_dut_a (
    .clk             (clk),
    .nrst            (nrst),
    .done_dispatch_i (a_dd),
    .restart_i       (a_rs),
    .res_dat_i       (a_res),
    .res_valid_i     (a_vld),
    .fifo_full_i     (a_full),
    .fifo_push_o     (a_push),
    .fifo_dat_o      (a_out),
    .done_collect_o  (a_done),
    .pe_clear_o      (a_pe),
    .busy_o          (a_busy)
  );

  result_collector #(.M(2), .K(4), .BW(2), .W(16)) u_dut_b (
    .clk             (clk),
    .nrst            (nrst),
    .done_dispatch_i (b_dd),
    .restart_i       (b_rs),
    .res_dat_i       (b_res),
    .res_valid_i     (b_vld),
    .fifo_full_i     (b_full),
    .fifo_push_o     (b_push),
    .fifo_dat_o      (b_out),
    .done_collect_o  (b_done),
    .pe_clear_o      (b_pe),
    .busy_o          (b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int a_idle_bad = 0;
  int b_idle_bad = 0;
  logic [63:0] a_log[$];
  logic [63:0] b_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat log and idle-payload monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_push) a_log.push_back(64'(a_out));
    else if (a_out != '0) a_idle_bad++;
    if (b_push) b_log.push_back(64'(b_out));
    else if (b_out != '0) b_idle_bad++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic dispatch_a();
    tick(); a_dd = 1'b1;
    tick(); a_dd = 1'b0;
  endtask

  task automatic dispatch_b();
    tick(); b_dd = 1'b1;
    tick(); b_dd = 1'b0;
  endtask

  task automatic restart_a();
    tick(); a_rs = 1'b1;
    tick(); a_rs = 1'b0;
    a_log.delete();
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      at_neg();
      if (a_done) break;
    end
    check(tag, 64'(a_done), 64'd1);
  endtask

  task automatic check_log(input string tag, input int which, input int n, input logic [63:0] e [4]);
    int sz;
    sz = (which == 0) ? a_log.size() : b_log.size();
    check($sformatf("%s_count", tag), 64'(sz), 64'(n));
    for (int i = 0; i < n && i < sz; i++)
      check($sformatf("%s_beat%0d", tag, i), (which == 0) ? a_log[i] : b_log[i], e[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    a_dd = 1'b0; a_rs = 1'b0; a_full = 1'b0; a_res = '0; a_vld = '0;
    b_dd = 1'b0; b_rs = 1'b0; b_full = 1'b0; b_res = '0; b_vld = '0;

    // Reset state
    at_neg(); at_neg();
    check("rst_push", 64'(a_push), 64'd0);
    check("rst_dat", 64'(a_out), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_pe_clear", 64'(a_pe), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_b_busy", 64'(b_busy), 64'd0);
    tick(); nrst = 1'b1;

    // 1: all valid, FIFO empty -> {1,2},{3,4} back to back
    a_res = {16'd4, 16'd3, 16'd2, 16'd1}; a_vld = 4'hF; a_log.delete();
    dispatch_a();
    at_neg();
    check("t1_busy_wait", 64'(a_busy), 64'd1);
    check("t1_nopush_wait", 64'(a_push), 64'd0);
    tick(); at_neg();
    check("t1_push0", 64'(a_push), 64'd1);
    check("t1_dat0", 64'(a_out), 64'h0002_0001);
    tick(); at_neg();
    check("t1_push1", 64'(a_push), 64'd1);
    check("t1_dat1", 64'(a_out), 64'h0004_0003);
    check("t1_done_early", 64'(a_done), 64'd0);
    tick(); at_neg();
    check("t1_push_done", 64'(a_push), 64'd0);
    check("t1_done", 64'(a_done), 64'd1);
    check("t1_pe_clear", 64'(a_pe), 64'd1);
    check("t1_busy_done", 64'(a_busy), 64'd0);
    tick(); at_neg();
    check("t1_pe_clear_pulse", 64'(a_pe), 64'd0);
    check("t1_done_sticky", 64'(a_done), 64'd1);
    tick();
    check_log("t1_log", 0, 2, '{64'h0002_0001, 64'h0004_0003, 64'd0, 64'd0});

    // 2: FIFO full for 3 cycles at the second group
    restart_a();
    at_neg();
    check("t2_done_cleared", 64'(a_done), 64'd0);
    dispatch_a();
    tick(); at_neg();
    check("t2_push0", 64'(a_push), 64'd1);
    tick(); a_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check($sformatf("t2_stall%0d_push", i), 64'(a_push), 64'd0);
      check($sformatf("t2_stall%0d_dat", i), 64'(a_out), 64'd0);
      check($sformatf("t2_stall%0d_busy", i), 64'(a_busy), 64'd1);
      tick();
    end
    a_full = 1'b0;
    at_neg();
    check("t2_push1", 64'(a_push), 64'd1);
    check("t2_dat1", 64'(a_out), 64'h0004_0003);
    tick(); at_neg();
    check("t2_done", 64'(a_done), 64'd1);
    tick();
    check_log("t2_log", 0, 2, '{64'h0002_0001, 64'h0004_0003, 64'd0, 64'd0});

    // 3: last PE late -> first group out, then wait in WAIT_RES
    restart_a();
    a_vld = 4'b0111;
    dispatch_a();
    tick(); at_neg();
    check("t3_push0", 64'(a_push), 64'd1);
    check("t3_dat0", 64'(a_out), 64'h0002_0001);
    tick(); at_neg();
    check("t3_nopush", 64'(a_push), 64'd0);
    tick(); tick(); at_neg();
    check("t3_wait_busy", 64'(a_busy), 64'd1);
    check("t3_wait_nodone", 64'(a_done), 64'd0);
    check("t3_wait_nopush", 64'(a_push), 64'd0);
    tick(); a_vld = 4'hF;
    at_neg();
    check("t3_nopush_in_wait", 64'(a_push), 64'd0);
    tick(); at_neg();
    check("t3_push1", 64'(a_push), 64'd1);
    check("t3_dat1", 64'(a_out), 64'h0004_0003);
    tick(); at_neg();
    check("t3_done", 64'(a_done), 64'd1);
    tick();
    check_log("t3_log", 0, 2, '{64'h0002_0001, 64'h0004_0003, 64'd0, 64'd0});

    // 4: async reset after the first push, then a clean rerun
    restart_a();
    dispatch_a();
    tick(); at_neg();
    check("t4_push0", 64'(a_push), 64'd1);
    tick();
    nrst = 1'b0;
    #1;
    check("t4_rst_push", 64'(a_push), 64'd0);
    check("t4_rst_dat", 64'(a_out), 64'd0);
    check("t4_rst_busy", 64'(a_busy), 64'd0);
    check("t4_rst_done", 64'(a_done), 64'd0);
    tick(); nrst = 1'b1; a_log.delete();
    dispatch_a();
    wait_done_a("t4_rerun_done", 20);
    tick();
    check_log("t4_log", 0, 2, '{64'h0002_0001, 64'h0004_0003, 64'd0, 64'd0});

    // 5: restart from DONE, new data
    restart_a();
    at_neg();
    check("t5_done_low", 64'(a_done), 64'd0);
    a_res = {16'd8, 16'd7, 16'd6, 16'd5};
    dispatch_a();
    at_neg();
    check("t5_done_low_busy", 64'(a_done), 64'd0);
    wait_done_a("t5_done", 20);
    tick();
    check_log("t5_log", 0, 2, '{64'h0006_0005, 64'h0008_0007, 64'd0, 64'd0});

    // Restart coinciding with a push: beat goes out, counters start over
    restart_a();
    a_res = {16'd4, 16'd3, 16'd2, 16'd1};
    dispatch_a();
    tick(); a_rs = 1'b1;
    at_neg();
    check("rp_push_with_restart", 64'(a_push), 64'd1);
    tick(); a_rs = 1'b0;
    at_neg();
    check("rp_idle_push", 64'(a_push), 64'd0);
    check("rp_idle_busy", 64'(a_busy), 64'd0);
    tick();
    check_log("rp_log1", 0, 1, '{64'h0002_0001, 64'd0, 64'd0, 64'd0});
    a_log.delete();
    dispatch_a();
    wait_done_a("rp_done", 20);
    tick();
    check_log("rp_log2", 0, 2, '{64'h0002_0001, 64'h0004_0003, 64'd0, 64'd0});

    // 6: K=4 -> four beats with a row wrap in the middle
    b_res = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    b_vld = 8'hFF; b_log.delete();
    dispatch_b();
    tick();
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check($sformatf("t6_push%0d", i), 64'(b_push), 64'd1);
      check($sformatf("t6_dat%0d", i), 64'(b_out), {32'd0, 16'(2 * i + 2), 16'(2 * i + 1)});
      tick();
    end
    at_neg();
    check("t6_done", 64'(b_done), 64'd1);
    check("t6_pe_clear", 64'(b_pe), 64'd1);
    tick();
    check_log("t6_log", 1, 4, '{64'h0002_0001, 64'h0004_0003, 64'h0006_0005, 64'h0008_0007});

    check("idle_dat_zero_a", 64'(a_idle_bad), 64'd0);
    check("idle_dat_zero_b", 64'(b_idle_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
